// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size codes, the
// miss-handling FSM state encoding and the latched request payload.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned CTRL_W     = 6;
    localparam int unsigned MAP_W      = 6;
    localparam int unsigned TAG_W      = 32;
    localparam int unsigned BE_W       = MEM_DATA_W / 8;

    // Access size/sign codes carried on ALU_Control_mem
    localparam logic [CTRL_W-1:0] CTRL_LW  = 6'h20;
    localparam logic [CTRL_W-1:0] CTRL_LB  = 6'h21;
    localparam logic [CTRL_W-1:0] CTRL_LBU = 6'h22;
    localparam logic [CTRL_W-1:0] CTRL_LH  = 6'h23;
    localparam logic [CTRL_W-1:0] CTRL_LHU = 6'h24;
    localparam logic [CTRL_W-1:0] CTRL_SW  = 6'h28;
    localparam logic [CTRL_W-1:0] CTRL_SB  = 6'h29;
    localparam logic [CTRL_W-1:0] CTRL_SH  = 6'h2A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REPLAY = 2'd2,
        DRAIN  = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [CTRL_W-1:0]     ctrl;
        logic [MAP_W-1:0]      map;
        logic                  regwr;
        logic                  rd;
        logic                  wr;
        logic [TAG_W-1:0]      tag;
    } mem_req_t;

    // Unrecognised codes are treated as word accesses
    function automatic mem_size_e size_of(input logic [CTRL_W-1:0] ctrl);
        mem_size_e sz;
        case (ctrl)
            CTRL_LB, CTRL_LBU, CTRL_SB: sz = SZ_BYTE;
            CTRL_LH, CTRL_LHU, CTRL_SH: sz = SZ_HALF;
            default:                    sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic for one access.
// Ports: ctrl/addr_lo select size and lane; wdata -> wlane (replicated store
// data) and be (byte enables); rdata -> ldata (extracted, extended load data);
// misalign flags a half/word access that is not naturally aligned.
module mem_align
    import mem_pkg::*;
(
    input  logic [CTRL_W-1:0]     ctrl,
    input  logic [1:0]            addr_lo,
    input  logic [MEM_DATA_W-1:0] wdata,
    input  logic [MEM_DATA_W-1:0] rdata,
    output logic [BE_W-1:0]       be,
    output logic [MEM_DATA_W-1:0] wlane,
    output logic [MEM_DATA_W-1:0] ldata,
    output logic                  misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables, store lane replication and alignment check
    always_comb begin
        be       = '0;
        wlane    = '0;
        misalign = 1'b0;
        case (size_of(ctrl))
            SZ_BYTE: begin
                be    = BE_W'(4'b0001 << addr_lo);
                wlane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be       = BE_W'(4'b0011 << addr_lo);
                wlane    = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            default: begin
                be       = '1;
                wlane    = wdata;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        byte_sel = 8'(rdata >> {addr_lo, 3'b000});
        half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});
        case (ctrl)
            CTRL_LB:  ldata = {{(MEM_DATA_W-8){byte_sel[7]}}, byte_sel};
            CTRL_LBU: ldata = {{(MEM_DATA_W-8){1'b0}}, byte_sel};
            CTRL_LH:  ldata = {{(MEM_DATA_W-16){half_sel[15]}}, half_sel};
            CTRL_LHU: ldata = {{(MEM_DATA_W-16){1'b0}}, half_sel};
            default:  ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: takes one resolved load/store per cycle from the LSQ,
// performs the same-cycle data-cache lookup, and registers a one-cycle
// writeback. A single outstanding miss is tracked by an IDLE/MISS/REPLAY/DRAIN
// FSM that holds mem_miss_halt to stop the LSQ dequeuing.
// Ports: CLK/RESET/FLUSH; *_mem request from the LSQ; dc_* cache request
// (combinational) and dc_hit/dc_rdata/dc_refill_done responses;
// mem_miss_halt back to the LSQ; wb_* registered writeback.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              MemRd_flag_mem,
    input  logic              MemWr_flag_mem,
    input  logic [ADDR_W-1:0] ALU_result_mem,
    input  logic [DATA_W-1:0] MemWrData_mem,
    input  logic [5:0]        ALU_Control_mem,
    input  logic              RegWr_flag_mem,
    input  logic [5:0]        RegWr_map_mem,
    input  logic [31:0]       instr_num_mem,
    output logic              dc_req,
    output logic              dc_we,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [3:0]        dc_be,
    input  logic              dc_hit,
    input  logic [DATA_W-1:0] dc_rdata,
    input  logic              dc_refill_done,
    output logic              mem_miss_halt,
    output logic              wb_valid,
    output logic              wb_regwr,
    output logic [5:0]        wb_map,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_instr_num,
    output logic              wb_misalign
);

    mem_state_e state_q, state_d;
    mem_req_t   req_q, req_d;
    mem_req_t   in_req, cur_req;

    logic                  accept_c;
    logic                  dc_req_c;
    logic [BE_W-1:0]       al_be;
    logic [MEM_DATA_W-1:0] al_wlane;
    logic [MEM_DATA_W-1:0] al_ldata;
    logic                  al_misalign;

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_regwr_q, wb_regwr_d;
    logic [MAP_W-1:0]      wb_map_q, wb_map_d;
    logic [MEM_DATA_W-1:0] wb_data_q, wb_data_d;
    logic [TAG_W-1:0]      wb_tag_q, wb_tag_d;
    logic                  wb_misalign_q, wb_misalign_d;

    // Incoming request; REPLAY works from the latched copy instead
    always_comb begin
        in_req.addr  = MEM_ADDR_W'(ALU_result_mem);
        in_req.wdata = MEM_DATA_W'(MemWrData_mem);
        in_req.ctrl  = ALU_Control_mem;
        in_req.map   = RegWr_map_mem;
        in_req.regwr = RegWr_flag_mem;
        in_req.rd    = MemRd_flag_mem;
        in_req.wr    = MemWr_flag_mem;
        in_req.tag   = instr_num_mem;
        cur_req      = (state_q == REPLAY) ? req_q : in_req;
    end

    assign mem_miss_halt = (state_q != IDLE);
    assign accept_c = (MemRd_flag_mem | MemWr_flag_mem) && (instr_num_mem != '0)
                      && !mem_miss_halt;

    mem_align u_align (
        .ctrl     (cur_req.ctrl),
        .addr_lo  (cur_req.addr[1:0]),
        .wdata    (cur_req.wdata),
        .rdata    (MEM_DATA_W'(dc_rdata)),
        .be       (al_be),
        .wlane    (al_wlane),
        .ldata    (al_ldata),
        .misalign (al_misalign)
    );

    // State and latched request register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Next-state: a flush never leaves a refill unaccounted for (DRAIN)
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (accept_c && !FLUSH && !al_misalign && !dc_hit) begin
                    state_d = MISS;
                    req_d   = in_req;
                end
            end
            MISS: begin
                if (FLUSH) begin
                    state_d = dc_refill_done ? IDLE : DRAIN;
                end else if (dc_refill_done) begin
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                state_d = (FLUSH || dc_hit) ? IDLE : MISS;
            end
            DRAIN: begin
                if (dc_refill_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: cache request and next writeback; squashed by FLUSH and reset
    always_comb begin
        dc_req_c      = 1'b0;
        wb_valid_d    = 1'b0;
        wb_regwr_d    = 1'b0;
        wb_map_d      = '0;
        wb_data_d     = '0;
        wb_tag_d      = '0;
        wb_misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c && !FLUSH && RESET) begin
                    if (al_misalign) begin
                        wb_valid_d    = 1'b1;
                        wb_misalign_d = 1'b1;
                        wb_map_d      = cur_req.map;
                        wb_tag_d      = cur_req.tag;
                    end else begin
                        dc_req_c = 1'b1;
                    end
                end
            end
            REPLAY: begin
                dc_req_c = !FLUSH && RESET;
            end
            default: dc_req_c = 1'b0;
        endcase
        if (dc_req_c && dc_hit) begin
            wb_valid_d = 1'b1;
            wb_regwr_d = cur_req.rd & cur_req.regwr;
            wb_map_d   = cur_req.map;
            wb_data_d  = cur_req.rd ? al_ldata : '0;
            wb_tag_d   = cur_req.tag;
        end
    end

    assign dc_req   = dc_req_c;
    assign dc_we    = dc_req_c & cur_req.wr;
    assign dc_addr  = dc_req_c ? ADDR_W'({cur_req.addr[MEM_ADDR_W-1:2], 2'b00}) : '0;
    assign dc_be    = dc_req_c ? 4'(al_be) : 4'b0000;
    assign dc_wdata = (dc_req_c && cur_req.wr) ? DATA_W'(al_wlane) : '0;

    // Writeback register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wb_valid_q    <= 1'b0;
            wb_regwr_q    <= 1'b0;
            wb_map_q      <= '0;
            wb_data_q     <= '0;
            wb_tag_q      <= '0;
            wb_misalign_q <= 1'b0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwr_q    <= wb_regwr_d;
            wb_map_q      <= wb_map_d;
            wb_data_q     <= wb_data_d;
            wb_tag_q      <= wb_tag_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_regwr     = wb_regwr_q;
    assign wb_map       = wb_map_q;
    assign wb_data      = DATA_W'(wb_data_q);
    assign wb_instr_num = wb_tag_q;
    assign wb_misalign  = wb_misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH;
    logic        MemRd_flag_mem, MemWr_flag_mem;
    logic [31:0] ALU_result_mem, MemWrData_mem;
    logic [5:0]  ALU_Control_mem;
    logic        RegWr_flag_mem;
    logic [5:0]  RegWr_map_mem;
    logic [31:0] instr_num_mem;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_be;
    logic        dc_hit;
    logic [31:0] dc_rdata;
    logic        dc_refill_done;
    logic        mem_miss_halt;
    logic        wb_valid, wb_regwr, wb_misalign;
    logic [5:0]  wb_map;
    logic [31:0] wb_data, wb_instr_num;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .MemRd_flag_mem(MemRd_flag_mem), .MemWr_flag_mem(MemWr_flag_mem),
        .ALU_result_mem(ALU_result_mem), .MemWrData_mem(MemWrData_mem),
        .ALU_Control_mem(ALU_Control_mem), .RegWr_flag_mem(RegWr_flag_mem),
        .RegWr_map_mem(RegWr_map_mem), .instr_num_mem(instr_num_mem),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_be(dc_be), .dc_hit(dc_hit), .dc_rdata(dc_rdata),
        .dc_refill_done(dc_refill_done), .mem_miss_halt(mem_miss_halt),
        .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_map(wb_map),
        .wb_data(wb_data), .wb_instr_num(wb_instr_num), .wb_misalign(wb_misalign)
    );

    typedef struct {
        logic        rd, wr;
        logic [5:0]  ctrl;
        logic [31:0] addr, wdata, rdata;
        logic        regwr;
        logic [5:0]  map;
        logic [31:0] tag;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_valid, e_regwr, e_mis;
        logic [31:0] e_data;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRd_flag_mem = 1'b0; MemWr_flag_mem = 1'b0; ALU_Control_mem = 6'h00;
        ALU_result_mem = 32'h0; MemWrData_mem = 32'h0; RegWr_flag_mem = 1'b0;
        RegWr_map_mem = 6'h00; instr_num_mem = 32'h0; FLUSH = 1'b0;
        dc_hit = 1'b0; dc_rdata = 32'h0; dc_refill_done = 1'b0;
    endtask

    // Present a request that misses; returns just after the accepting edge
    task automatic issue_miss(input logic w, input logic [5:0] c, input logic [31:0] a,
                              input logic [31:0] wd, input logic [5:0] m, input logic [31:0] t);
        @(negedge CLK);
        idle_inputs();
        MemRd_flag_mem = !w; MemWr_flag_mem = w; ALU_Control_mem = c;
        ALU_result_mem = a; MemWrData_mem = wd; RegWr_flag_mem = !w;
        RegWr_map_mem = m; instr_num_mem = t;
        #1 chk($sformatf("miss issue dc_req tag%0d", t), 32'(dc_req), 32'd1);
        @(posedge CLK);
        #1 idle_inputs();
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [5:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic regwr,
                                input logic [5:0] map, input logic [31:0] tag,
                                input logic e_req, input logic e_we, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic e_valid, input logic e_regwr, input logic e_mis,
                                input logic [31:0] e_data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.regwr = regwr; v.map = map; v.tag = tag;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_valid = e_valid; v.e_regwr = e_regwr;
        v.e_mis = e_mis; v.e_data = e_data;
        return v;
    endfunction

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int halt_cnt, wb_cyc, wb_cnt;

        //          rd wr ctrl      addr          wdata         rdata         rw map  tag    req we e_addr        be       e_wdata       val rw mis e_data
        vecs[0]  = mk(1, 0, CTRL_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1, 6'd5,  32'd1,  1, 0, 32'h100, 4'hF, 32'h0,        1, 1, 0, 32'hDEADBEEF);
        vecs[1]  = mk(1, 0, CTRL_LB,  32'h103, 32'h0,        32'h80FF0000, 1, 6'd6,  32'd2,  1, 0, 32'h100, 4'h8, 32'h0,        1, 1, 0, 32'hFFFFFF80);
        vecs[2]  = mk(1, 0, CTRL_LBU, 32'h103, 32'h0,        32'h80FF0000, 1, 6'd7,  32'd3,  1, 0, 32'h100, 4'h8, 32'h0,        1, 1, 0, 32'h00000080);
        vecs[3]  = mk(1, 0, CTRL_LH,  32'h102, 32'h0,        32'h80FF0000, 1, 6'd8,  32'd4,  1, 0, 32'h100, 4'hC, 32'h0,        1, 1, 0, 32'hFFFF80FF);
        vecs[4]  = mk(1, 0, CTRL_LHU, 32'h102, 32'h0,        32'h80FF0000, 1, 6'd9,  32'd5,  1, 0, 32'h100, 4'hC, 32'h0,        1, 1, 0, 32'h000080FF);
        vecs[5]  = mk(1, 0, CTRL_LB,  32'h101, 32'h0,        32'h12345678, 1, 6'd10, 32'd6,  1, 0, 32'h100, 4'h2, 32'h0,        1, 1, 0, 32'h00000056);
        vecs[6]  = mk(1, 0, CTRL_LHU, 32'h400, 32'h0,        32'h0000FFFE, 1, 6'd11, 32'd7,  1, 0, 32'h400, 4'h3, 32'h0,        1, 1, 0, 32'h0000FFFE);
        vecs[7]  = mk(0, 1, CTRL_SH,  32'h202, 32'h00001234, 32'h0,        0, 6'd0,  32'd8,  1, 1, 32'h200, 4'hC, 32'h12341234, 1, 0, 0, 32'h0);
        vecs[8]  = mk(0, 1, CTRL_SB,  32'h001, 32'h000000AB, 32'h0,        1, 6'd12, 32'd9,  1, 1, 32'h000, 4'h2, 32'hABABABAB, 1, 0, 0, 32'h0);
        vecs[9]  = mk(0, 1, CTRL_SW,  32'h204, 32'hCAFEF00D, 32'h0,        0, 6'd0,  32'd10, 1, 1, 32'h204, 4'hF, 32'hCAFEF00D, 1, 0, 0, 32'h0);
        vecs[10] = mk(1, 0, CTRL_LH,  32'h401, 32'h0,        32'h0,        1, 6'd13, 32'd11, 0, 0, 32'h0,   4'h0, 32'h0,        1, 0, 1, 32'h0);
        vecs[11] = mk(1, 0, CTRL_LW,  32'h302, 32'h0,        32'h0,        1, 6'd14, 32'd12, 0, 0, 32'h0,   4'h0, 32'h0,        1, 0, 1, 32'h0);
        vecs[12] = mk(0, 1, CTRL_SW,  32'h001, 32'h55555555, 32'h0,        0, 6'd15, 32'd13, 0, 0, 32'h0,   4'h0, 32'h0,        1, 0, 1, 32'h0);
        vecs[13] = mk(1, 0, CTRL_LW,  32'h100, 32'h0,        32'h11111111, 1, 6'd16, 32'd0,  0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0);
        vecs[14] = mk(1, 0, CTRL_LB,  32'h000, 32'h0,        32'h0000007F, 1, 6'd17, 32'd14, 1, 0, 32'h000, 4'h1, 32'h0,        1, 1, 0, 32'h0000007F);

        // Reset state, with a live request on the inputs
        idle_inputs();
        RESET = 1'b0;
        MemRd_flag_mem = 1'b1; ALU_Control_mem = CTRL_LW; ALU_result_mem = 32'h100;
        instr_num_mem = 32'd1; dc_hit = 1'b1;
        #12;
        chk("reset dc_req", 32'(dc_req), 32'd0);
        chk("reset dc_be", 32'(dc_be), 32'd0);
        chk("reset dc_addr", dc_addr, 32'd0);
        chk("reset halt", 32'(mem_miss_halt), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_instr_num", wb_instr_num, 32'd0);
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Table of single-cycle hit / misaligned accesses
        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            MemRd_flag_mem = vecs[i].rd; MemWr_flag_mem = vecs[i].wr;
            ALU_Control_mem = vecs[i].ctrl; ALU_result_mem = vecs[i].addr;
            MemWrData_mem = vecs[i].wdata; RegWr_flag_mem = vecs[i].regwr;
            RegWr_map_mem = vecs[i].map; instr_num_mem = vecs[i].tag;
            dc_hit = 1'b1; dc_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d dc_req", i), 32'(dc_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d dc_we", i), 32'(dc_we), 32'(vecs[i].e_we));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d dc_addr", i), dc_addr, vecs[i].e_addr);
                chk($sformatf("v%0d dc_be", i), 32'(dc_be), 32'(vecs[i].e_be));
            end
            if (vecs[i].e_we) chk($sformatf("v%0d dc_wdata", i), dc_wdata, vecs[i].e_wdata);
            @(posedge CLK);
            #1;
            idle_inputs();
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d wb_regwr", i), 32'(wb_regwr), 32'(vecs[i].e_regwr));
            chk($sformatf("v%0d wb_misalign", i), 32'(wb_misalign), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_data);
            chk($sformatf("v%0d wb_map", i), 32'(wb_map),
                vecs[i].e_valid ? 32'(vecs[i].map) : 32'd0);
            chk($sformatf("v%0d wb_instr_num", i), wb_instr_num,
                vecs[i].e_valid ? vecs[i].tag : 32'd0);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d wb pulse", i), 32'(wb_valid), 32'd0);
        end

        // LW miss, refill 5 cycles later, replay hit
        issue_miss(1'b0, CTRL_LW, 32'h300, 32'h0, 6'd21, 32'd50);
        halt_cnt = 0; wb_cyc = 0; wb_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            idle_inputs();
            dc_refill_done = (c == 5);
            dc_hit = (c == 6);
            dc_rdata = (c == 6) ? 32'h11223344 : 32'h0;
            if (c == 2) begin
                MemRd_flag_mem = 1'b1; ALU_Control_mem = CTRL_LW;
                ALU_result_mem = 32'h500; instr_num_mem = 32'd99; RegWr_flag_mem = 1'b1;
            end
            #1;
            if (mem_miss_halt) halt_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_cyc == 0) begin
                    wb_cyc = c;
                    chk("miss wb_data", wb_data, 32'h11223344);
                    chk("miss wb_instr_num", wb_instr_num, 32'd50);
                    chk("miss wb_map", 32'(wb_map), 32'd21);
                    chk("miss wb_regwr", 32'(wb_regwr), 32'd1);
                end
            end
            if (c == 2) chk("miss ignores lsq dc_req", 32'(dc_req), 32'd0);
            if (c == 6) begin
                chk("replay dc_req", 32'(dc_req), 32'd1);
                chk("replay dc_addr", dc_addr, 32'h300);
            end
        end
        chk("miss halt cycles", 32'(halt_cnt), 32'd6);
        chk("miss wb cycle", 32'(wb_cyc), 32'd7);
        chk("miss wb count", 32'(wb_cnt), 32'd1);

        // FLUSH in MISS, refill 3 cycles later -> DRAIN, no writeback
        issue_miss(1'b0, CTRL_LW, 32'h300, 32'h0, 6'd22, 32'd51);
        wb_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            idle_inputs();
            FLUSH = (c == 2);
            dc_refill_done = (c == 5);
            dc_hit = 1'b1;
            #1;
            if (wb_valid) wb_cnt++;
            if (c == 4) chk("drain dc_req", 32'(dc_req), 32'd0);
            if (c == 5) chk("drain halt before refill", 32'(mem_miss_halt), 32'd1);
            if (c == 6) chk("drain halt after refill", 32'(mem_miss_halt), 32'd0);
        end
        chk("drain wb count", 32'(wb_cnt), 32'd0);

        // Simultaneous FLUSH and refill in MISS -> straight to IDLE
        issue_miss(1'b0, CTRL_LW, 32'h304, 32'h0, 6'd23, 32'd52);
        wb_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            idle_inputs();
            FLUSH = (c == 2);
            dc_refill_done = (c == 2);
            dc_hit = 1'b1;
            #1;
            if (wb_valid) wb_cnt++;
            if (c == 3) begin
                chk("flush+refill halt", 32'(mem_miss_halt), 32'd0);
                chk("flush+refill no replay", 32'(dc_req), 32'd0);
            end
        end
        chk("flush+refill wb count", 32'(wb_cnt), 32'd0);

        // Refill pulse while IDLE is ignored
        @(negedge CLK);
        idle_inputs();
        dc_refill_done = 1'b1;
        @(negedge CLK);
        idle_inputs();
        #1 chk("idle refill halt", 32'(mem_miss_halt), 32'd0);

        // FLUSH in REPLAY discards the latched request
        issue_miss(1'b0, CTRL_LW, 32'h308, 32'h0, 6'd24, 32'd53);
        wb_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            idle_inputs();
            dc_refill_done = (c == 1);
            FLUSH = (c == 2);
            dc_hit = (c == 2);
            #1;
            if (wb_valid) wb_cnt++;
            if (c == 2) chk("replay flush halt in replay", 32'(mem_miss_halt), 32'd1);
            if (c == 3) chk("replay flush halt after", 32'(mem_miss_halt), 32'd0);
        end
        chk("replay flush wb count", 32'(wb_cnt), 32'd0);

        // Store miss, second miss on replay, then hit
        issue_miss(1'b1, CTRL_SW, 32'h600, 32'hA5A50F0F, 6'd0, 32'd60);
        wb_cyc = 0; wb_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            idle_inputs();
            dc_refill_done = (c == 1) || (c == 4);
            dc_hit = (c == 5);
            #1;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_cyc == 0) begin
                    wb_cyc = c;
                    chk("store wb_regwr", 32'(wb_regwr), 32'd0);
                    chk("store wb_instr_num", wb_instr_num, 32'd60);
                end
            end
            if (c == 2) chk("store replay1 dc_we", 32'(dc_we), 32'd1);
            if (c == 3) begin
                chk("store remiss halt", 32'(mem_miss_halt), 32'd1);
                chk("store remiss dc_req", 32'(dc_req), 32'd0);
            end
            if (c == 5) begin
                chk("store replay2 dc_we", 32'(dc_we), 32'd1);
                chk("store replay2 dc_wdata", dc_wdata, 32'hA5A50F0F);
                chk("store replay2 dc_be", 32'(dc_be), 32'hF);
            end
        end
        chk("store wb cycle", 32'(wb_cyc), 32'd6);
        chk("store wb count", 32'(wb_cnt), 32'd1);

        // FLUSH in IDLE squashes a hitting request
        @(negedge CLK);
        idle_inputs();
        MemRd_flag_mem = 1'b1; ALU_Control_mem = CTRL_LW; ALU_result_mem = 32'h100;
        RegWr_flag_mem = 1'b1; RegWr_map_mem = 6'd3; instr_num_mem = 32'd80;
        dc_hit = 1'b1; dc_rdata = 32'h12345678; FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        idle_inputs();
        chk("idle flush wb_valid", 32'(wb_valid), 32'd0);
        chk("idle flush halt", 32'(mem_miss_halt), 32'd0);

        // Async reset mid-MISS
        issue_miss(1'b0, CTRL_LW, 32'h700, 32'h0, 6'd25, 32'd70);
        @(negedge CLK);
        MemRd_flag_mem = 1'b1; ALU_Control_mem = CTRL_LW; ALU_result_mem = 32'h100;
        instr_num_mem = 32'd71; RegWr_flag_mem = 1'b1;
        #1 chk("pre-reset halt", 32'(mem_miss_halt), 32'd1);
        #1 RESET = 1'b0;
        #1;
        chk("mid-miss reset halt", 32'(mem_miss_halt), 32'd0);
        chk("mid-miss reset dc_req", 32'(dc_req), 32'd0);
        chk("mid-miss reset dc_we", 32'(dc_we), 32'd0);
        chk("mid-miss reset dc_be", 32'(dc_be), 32'd0);
        chk("mid-miss reset wb_valid", 32'(wb_valid), 32'd0);
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        dc_refill_done = 1'b1;
        @(negedge CLK);
        idle_inputs();
        #1 chk("post-reset halt", 32'(mem_miss_halt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
